// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
// Bundles the requester-side and memory-side signals of mem_arbiter.
//
//   modport master : the arbiter's view. It samples requests and memory responses and drives
//                    the completion pulses, the read data and the memory command.
//   modport slave  : the environment's view, i.e. the requesters plus the memory model.
//
// Signal groups:
//   ireq_*  instruction-fetch side (read-only)
//   dreq_*  load/store side (read/write, write wins when both are set)
//   mem_*   shared variable-latency memory
interface mem_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 64
);
  // Instruction side
  logic                  ireq_read_i;
  logic [ADDR_WIDTH-1:0] ireq_addr_i;
  logic [DATA_WIDTH-1:0] ireq_data_o;
  logic                  ireq_done_o;
  // Data side
  logic                  dreq_read_i;
  logic                  dreq_write_i;
  logic [ADDR_WIDTH-1:0] dreq_addr_i;
  logic [DATA_WIDTH-1:0] dreq_data_i;
  logic [DATA_WIDTH-1:0] dreq_data_o;
  logic                  dreq_done_o;
  // Memory side
  logic                  mem_read_request_o;
  logic                  mem_write_en_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_data_o;
  logic [DATA_WIDTH-1:0] mem_read_data_i;
  logic                  mem_successful_access_i;

  modport master (
    input  ireq_read_i, ireq_addr_i,
    input  dreq_read_i, dreq_write_i, dreq_addr_i, dreq_data_i,
    input  mem_read_data_i, mem_successful_access_i,
    output ireq_data_o, ireq_done_o,
    output dreq_data_o, dreq_done_o,
    output mem_read_request_o, mem_write_en_o, mem_addr_o, mem_data_o
  );

  modport slave (
    output ireq_read_i, ireq_addr_i,
    output dreq_read_i, dreq_write_i, dreq_addr_i, dreq_data_i,
    output mem_read_data_i, mem_successful_access_i,
    input  ireq_data_o, ireq_done_o,
    input  dreq_data_o, dreq_done_o,
    input  mem_read_request_o, mem_write_en_o, mem_addr_o, mem_data_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one variable-latency memory between the instruction-fetch side (read-only) and the
// data side (read/write). One requester owns the memory at a time; its address, write data and
// command are latched at grant and held on the memory bus until the memory strobes
// mem_successful_access_i. The owner then sees a one-cycle done pulse with registered read data.
//
// Ports:
//   clk_i   clock
//   arst_i  asynchronous, active-high reset; abandons any transfer, no done pulse follows
//   bus     mem_arbiter_if.master: ireq_* / dreq_* requester handshakes, mem_* memory port
//
// Configuration:
//   MEM_ARB_ROUND_ROBIN_EN  when defined, a tie in IDLE goes to the side that did not own the
//                           previous grant (I wins the first tie after reset). When undefined,
//                           the data side always beats the instruction side.
//
// Cycle shape: IDLE (grant edge) -> BUSY (1+ cycles, command on bus) -> RESP (done pulse) -> IDLE.
module mem_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 64
) (
  input logic          clk_i,
  input logic          arst_i,
  mem_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StResp
  } state_e;

  localparam logic OwnerI = 1'b0;
  localparam logic OwnerD = 1'b1;

  state_e state_q, state_d;

  logic                  owner_q, owner_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] idata_q, idata_d;
  logic [DATA_WIDTH-1:0] ddata_q, ddata_d;

  logic ireq_any;
  logic dreq_any;
  logic req_any;
  logic grant_owner;
  logic grant_fire;

  logic                  mem_read_request;
  logic                  mem_write_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  ireq_done;
  logic                  dreq_done;

  assign ireq_any   = bus.ireq_read_i;
  assign dreq_any   = bus.dreq_read_i | bus.dreq_write_i;
  assign req_any    = ireq_any | dreq_any;
  assign grant_fire = (state_q == StIdle) && req_any;

  // ---------------------------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------------------------
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_owner_q, last_owner_d;

  always_comb begin
    if (ireq_any && dreq_any) begin
      // Tie: hand the memory to whoever did not have it last time.
      grant_owner = (last_owner_q == OwnerD) ? OwnerI : OwnerD;
    end else begin
      grant_owner = dreq_any ? OwnerD : OwnerI;
    end
  end

  always_comb begin
    last_owner_d = last_owner_q;
    if (grant_fire) begin
      last_owner_d = grant_owner;
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      last_owner_q <= OwnerD;
    end else begin
      last_owner_q <= last_owner_d;
    end
  end
`else
  assign grant_owner = dreq_any ? OwnerD : OwnerI;
`endif

  // ---------------------------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req_any) begin
          state_d = StBusy;
        end
      end
      StBusy: begin
        // No timeout: memory latency is unbounded.
        if (bus.mem_successful_access_i) begin
          state_d = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    mem_read_request = 1'b0;
    mem_write_en     = 1'b0;
    mem_addr         = '0;
    mem_data         = '0;
    ireq_done        = 1'b0;
    dreq_done        = 1'b0;
    unique case (state_q)
      StBusy: begin
        // The command is repeated every BUSY cycle; a re-asserted write is harmless.
        mem_read_request = ~write_q;
        mem_write_en     = write_q;
        mem_addr         = addr_q;
        mem_data         = wdata_q;
      end
      StResp: begin
        ireq_done = (owner_q == OwnerI);
        dreq_done = (owner_q == OwnerD);
      end
      default: begin
      end
    endcase
  end

  // ---------------------------------------------------------------------------------------------
  // Latched command and returned data
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    owner_d = owner_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    idata_d = idata_q;
    ddata_d = ddata_q;

    if (grant_fire) begin
      owner_d = grant_owner;
      if (grant_owner == OwnerD) begin
        addr_d  = bus.dreq_addr_i;
        wdata_d = bus.dreq_data_i;
        // Write takes precedence when read and write are both raised.
        write_d = bus.dreq_write_i;
      end else begin
        addr_d  = bus.ireq_addr_i;
        wdata_d = '0;
        write_d = 1'b0;
      end
    end

    // Captured on writes too; the value is meaningless then but keeps the path uniform.
    if ((state_q == StBusy) && bus.mem_successful_access_i) begin
      if (owner_q == OwnerD) begin
        ddata_d = bus.mem_read_data_i;
      end else begin
        idata_d = bus.mem_read_data_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      owner_q <= OwnerD;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      idata_q <= '0;
      ddata_q <= '0;
    end else begin
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      idata_q <= idata_d;
      ddata_q <= ddata_d;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Bus drive
  // ---------------------------------------------------------------------------------------------
  assign bus.mem_read_request_o = mem_read_request;
  assign bus.mem_write_en_o     = mem_write_en;
  assign bus.mem_addr_o         = mem_addr;
  assign bus.mem_data_o         = mem_data;
  assign bus.ireq_done_o        = ireq_done;
  assign bus.dreq_done_o        = dreq_done;
  assign bus.ireq_data_o        = idata_q;
  assign bus.dreq_data_o        = ddata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Self-checking bench for mem_arbiter. Drives both requesters and plays the memory with a
// random access latency. Expected behaviour comes from a transaction-level model: an arbitration
// rule function, a reference memory (associative array) and the documented cycle timing.
// Build with +define+MEM_ARB_ROUND_ROBIN_EN to check the round-robin variant.
module tb_mem_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 64;

  logic clk_i = 1'b0;
  logic arst_i;

  always #5 clk_i = ~clk_i;

  mem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  mem_arbiter #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .bus    (bus)
  );

  int n_total = 0;
  int n_bad   = 0;

  logic [DW-1:0] mem_q [logic [AW-1:0]];  // reference memory contents
  bit            last_d;                  // side that owned the most recent grant

  // Request staged to appear during the first BUSY cycle of another transfer.
  bit            st_pending;
  bit            st_is_d;
  bit            st_rd;
  bit            st_wr;
  logic [AW-1:0] st_addr;
  logic [DW-1:0] st_data;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    if (mem_q.exists(a)) return mem_q[a];
    return a[31:0] ^ a[63:32] ^ 32'h5A5A_C3C3;
  endfunction

  // Which side wins when the arbiter looks at the requests in IDLE.
  function automatic bit pick_d(input bit i_req, input bit d_req);
    if (!i_req) return 1'b1;
    if (!d_req) return 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    return !last_d;
`else
    return 1'b1;
`endif
  endfunction

  task automatic check_quiet(input string tag);
    check_eq({tag, "_mem"}, {bus.mem_read_request_o, bus.mem_write_en_o,
                             |bus.mem_addr_o, |bus.mem_data_o}, 64'd0);
    check_eq({tag, "_done"}, {bus.ireq_done_o, bus.dreq_done_o}, 64'd0);
  endtask

  task automatic set_i(input bit rd, input logic [AW-1:0] a);
    bus.ireq_read_i = rd;
    bus.ireq_addr_i = a;
  endtask

  task automatic set_d(input bit rd, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.dreq_read_i  = rd;
    bus.dreq_write_i = wr;
    bus.dreq_addr_i  = a;
    bus.dreq_data_i  = d;
  endtask

  // Called at a negedge in IDLE with the owner's request present; returns at the RESP negedge.
  task automatic serve(input bit own_d, input int lat);
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    logic [DW-1:0] rd;
    bit            w;
    w      = own_d && bus.dreq_write_i;
    a      = own_d ? bus.dreq_addr_i : bus.ireq_addr_i;
    wd     = bus.dreq_data_i;
    rd     = '0;
    last_d = own_d;
    for (int k = 0; k <= lat; k++) begin
      @(negedge clk_i);
      check_eq("busy_addr", bus.mem_addr_o, a);
      check_eq("busy_rreq", bus.mem_read_request_o, !w);
      check_eq("busy_wen", bus.mem_write_en_o, w);
      if (w) check_eq("busy_wdata", bus.mem_data_o, wd);
      check_eq("busy_done", {bus.ireq_done_o, bus.dreq_done_o}, 64'd0);
      if (k == 0 && st_pending) begin
        if (st_is_d) set_d(st_rd, st_wr, st_addr, st_data);
        else         set_i(st_rd, st_addr);
        st_pending = 1'b0;
      end
      if (k == lat) begin
        rd = w ? $urandom : mem_rd(a);
        bus.mem_successful_access_i = 1'b1;
        bus.mem_read_data_i         = rd;
      end else begin
        bus.mem_read_data_i = $urandom;  // garbage must not be captured
      end
    end
    @(negedge clk_i);
    bus.mem_successful_access_i = 1'b0;
    bus.mem_read_data_i         = $urandom;
    check_eq("resp_done_own", own_d ? bus.dreq_done_o : bus.ireq_done_o, 64'd1);
    check_eq("resp_done_other", own_d ? bus.ireq_done_o : bus.dreq_done_o, 64'd0);
    if (!w) check_eq("resp_data", own_d ? bus.dreq_data_o : bus.ireq_data_o, rd);
    check_eq("resp_mem", {bus.mem_read_request_o, bus.mem_write_en_o,
                          |bus.mem_addr_o, |bus.mem_data_o}, 64'd0);
    if (w) mem_q[a] = wd;
    if (own_d) set_d(1'b0, 1'b0, '0, '0);
    else       set_i(1'b0, '0);
  endtask

  // stagger: 0 both raised together, 1 I first then D during I's BUSY, 2 the reverse.
  task automatic run(input bit i_on, input bit d_rd, input bit d_wr, input logic [AW-1:0] ia,
                     input logic [AW-1:0] da, input logic [DW-1:0] dd, input int stagger,
                     input int lat1, input int lat2);
    bit d_on;
    bit first_d;
    d_on = d_rd | d_wr;
    check_quiet("idle");
    if (i_on && d_on && stagger != 0) begin
      first_d    = (stagger == 2);
      st_pending = 1'b1;
      st_is_d    = !first_d;
      st_rd      = first_d ? 1'b1 : d_rd;
      st_wr      = first_d ? 1'b0 : d_wr;
      st_addr    = first_d ? ia : da;
      st_data    = dd;
      if (first_d) set_d(d_rd, d_wr, da, dd);
      else         set_i(1'b1, ia);
    end else begin
      if (i_on) set_i(1'b1, ia);
      if (d_on) set_d(d_rd, d_wr, da, dd);
      first_d = pick_d(i_on, d_on);
    end
    serve(first_d, lat1);
    @(negedge clk_i);
    check_quiet("gap");
    if (i_on && d_on) begin
      serve(!first_d, lat2);
      @(negedge clk_i);
      check_quiet("gap2");
    end
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return {$urandom, $urandom};
    return AW'($urandom_range(0, 15) * 4);
  endfunction

  initial begin
    set_i(1'b0, '0);
    set_d(1'b0, 1'b0, '0, '0);
    bus.mem_read_data_i         = '0;
    bus.mem_successful_access_i = 1'b0;
    st_pending                  = 1'b0;
    last_d                      = 1'b1;
    arst_i                      = 1'b1;
    #1;
    check_quiet("reset");
    check_eq("reset_idata", bus.ireq_data_o, 64'd0);
    check_eq("reset_ddata", bus.dreq_data_o, 64'd0);
    repeat (2) @(negedge clk_i);
    arst_i = 1'b0;

    // Ties right after reset exercise the initial last-owner value.
    run(1'b1, 1'b1, 1'b0, 64'h0, 64'h8, 32'h0, 0, 1, 2);
    run(1'b1, 1'b1, 1'b0, 64'h4, 64'hC, 32'h0, 0, 0, 1);

    // Single I read of a known word, three BUSY cycles.
    mem_q[64'h100] = 32'hDEAD_BEEF;
    run(1'b1, 1'b0, 1'b0, 64'h100, 64'h0, 32'h0, 0, 2, 0);

    // D write, then read it back.
    run(1'b0, 1'b0, 1'b1, 64'h0, 64'h40, 32'h1234_5678, 0, 1, 0);
    run(1'b0, 1'b1, 1'b0, 64'h0, 64'h40, 32'h0, 0, 0, 0);
    check_eq("readback_0x40", bus.dreq_data_o, 64'h1234_5678);

    // Read and write both set: a write only.
    run(1'b0, 1'b1, 1'b1, 64'h0, 64'h44, 32'hCAFE_F00D, 0, 2, 0);

    // Strobe in the first BUSY cycle on both back-to-back grants.
    run(1'b1, 1'b1, 1'b0, 64'h44, 64'h100, 32'h0, 0, 0, 0);

    // Asynchronous reset while BUSY.
    set_i(1'b1, 64'h200);
    @(negedge clk_i);
    check_eq("rst_pre_rreq", bus.mem_read_request_o, 64'd1);
    #2 arst_i = 1'b1;
    #1;
    check_quiet("rst_async");
    check_eq("rst_idata", bus.ireq_data_o, 64'd0);
    @(negedge clk_i);
    arst_i = 1'b0;
    last_d = 1'b1;
    serve(1'b0, 1);
    @(negedge clk_i);
    check_quiet("rst_after");

    // Randomized traffic.
    for (int n = 0; n < 200; n++) begin
      bit i_on;
      int dk;
      int stg;
      i_on = 1'($urandom_range(0, 1));
      dk   = $urandom_range(0, 3);
      if (!i_on && dk == 0) i_on = 1'b1;
      stg = (i_on && dk != 0) ? $urandom_range(0, 2) : 0;
      run(i_on, dk == 1 || dk == 3, dk >= 2, rand_addr(), rand_addr(), $urandom, stg,
          $urandom_range(0, 3), $urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk_i);
        check_quiet("idle_gap");
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
